// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: datapath defaults, main-decoder opcodes
// and the instruction fetch memory FSM state encoding.
package riscv_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // WAIT_KILL: a request is outstanding but its response belongs to a
  // path that was abandoned by a redirect.
  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_WAIT,
    FETCH_WAIT_KILL
  } fetch_state_e;

endpackage

// File: rtl/instr_queue.sv
// Two-deep FIFO of fetched {word, pc} pairs. The head always lives in slot 0,
// so the decode-facing outputs come straight from registers.
module instr_queue
  import riscv_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic [31:0]     push_word_i,
  input  logic [XLEN-1:0] push_pc_i,
  input  logic            pop_i,
  input  logic            flush_i,
  output logic [1:0]      count_o,
  output logic [31:0]     head_word_o,
  output logic [XLEN-1:0] head_pc_o,
  output logic            head_valid_o
);

  logic [31:0]     word_q [2];
  logic [XLEN-1:0] pc_q   [2];
  logic [1:0]      count_q;

  // Flush beats push so a response landing in the redirect cycle is dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q   <= 2'd0;
      word_q[0] <= '0;
      word_q[1] <= '0;
      pc_q[0]   <= RESET_PC;
      pc_q[1]   <= RESET_PC;
    end else if (flush_i) begin
      count_q <= 2'd0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (count_q == 2'd0) begin
            word_q[0] <= push_word_i;
            pc_q[0]   <= push_pc_i;
          end else begin
            word_q[1] <= push_word_i;
            pc_q[1]   <= push_pc_i;
          end
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          word_q[0] <= word_q[1];
          pc_q[0]   <= pc_q[1];
          count_q   <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd2) begin
            word_q[0] <= word_q[1];
            pc_q[0]   <= pc_q[1];
            word_q[1] <= push_word_i;
            pc_q[1]   <= push_pc_i;
          end else begin
            word_q[0] <= push_word_i;
            pc_q[0]   <= push_pc_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign count_o      = count_q;
  assign head_word_o  = word_q[0];
  assign head_pc_o    = pc_q[0];
  assign head_valid_o = (count_q != 2'd0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: owns the PC, talks to instruction memory over req/gnt/rvalid
// and hands queued words to decode, honouring PCSrc redirects on hand-off.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] PCTarget,
  output logic            IMEM_REQ,
  output logic [XLEN-1:0] IMEM_ADDR,
  input  logic            IMEM_GNT,
  input  logic            IMEM_RVALID,
  input  logic [31:0]     IMEM_RDATA,
  output logic            INSTR_VALID,
  input  logic            INSTR_READY,
  output logic [31:0]     INSTR,
  output logic [6:0]      OP6_0,
  output logic [XLEN-1:0] INSTR_PC,
  output logic [XLEN-1:0] PCPlus4
);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q;
  logic            run_q;

  logic [1:0]      q_count;
  logic [31:0]     head_word;
  logic            consume, redirect, grant, push;
  logic [XLEN-1:0] target_aligned;

  assign consume        = INSTR_VALID & INSTR_READY;
  assign redirect       = consume & PCSrc;
  assign grant          = IMEM_REQ & IMEM_GNT;
  assign push           = (state_q == FETCH_WAIT) & IMEM_RVALID;
  assign target_aligned = PCTarget & ~XLEN'(3);

  // Only request from IDLE with a free slot, which keeps count + outstanding <= 2.
  assign IMEM_REQ  = run_q & (state_q == FETCH_IDLE) & (q_count < 2'd2);
  assign IMEM_ADDR = pc_q;

  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = target_aligned;
    end else if (grant) begin
      pc_d = pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= FETCH_IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      run_q    <= 1'b0;
    end else begin
      run_q <= 1'b1;
      pc_q  <= pc_d;
      if (grant) begin
        req_pc_q <= pc_q;
      end
      case (state_q)
        FETCH_IDLE: begin
          if (grant) begin
            state_q <= redirect ? FETCH_WAIT_KILL : FETCH_WAIT;
          end
        end
        FETCH_WAIT: begin
          if (IMEM_RVALID) begin
            state_q <= FETCH_IDLE;
          end else if (redirect) begin
            state_q <= FETCH_WAIT_KILL;
          end
        end
        FETCH_WAIT_KILL: begin
          if (IMEM_RVALID) begin
            state_q <= FETCH_IDLE;
          end
        end
        default: state_q <= FETCH_IDLE;
      endcase
    end
  end

  instr_queue #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_queue (
    .clk_i        (CLK),
    .rst_ni       (RST),
    .push_i       (push),
    .push_word_i  (IMEM_RDATA),
    .push_pc_i    (req_pc_q),
    .pop_i        (consume),
    .flush_i      (redirect),
    .count_o      (q_count),
    .head_word_o  (head_word),
    .head_pc_o    (INSTR_PC),
    .head_valid_o (INSTR_VALID)
  );

  assign INSTR   = head_word;
  assign OP6_0   = head_word[6:0];
  assign PCPlus4 = INSTR_PC + XLEN'(4);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: cycle table for the basic fetch flow, directed
// corner sequences, then random traffic against an architectural PC model.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        PCSrc = 1'b0;
  logic [31:0] PCTarget = '0;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_GNT = 1'b0;
  logic        IMEM_RVALID = 1'b0;
  logic [31:0] IMEM_RDATA = '0;
  logic        INSTR_VALID;
  logic        INSTR_READY = 1'b0;
  logic [31:0] INSTR;
  logic [6:0]  OP6_0;
  logic [31:0] INSTR_PC;
  logic [31:0] PCPlus4;

  always #5 CLK = ~CLK;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .CLK(CLK), .RST(RST), .PCSrc(PCSrc), .PCTarget(PCTarget),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_GNT(IMEM_GNT),
    .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA),
    .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY), .INSTR(INSTR),
    .OP6_0(OP6_0), .INSTR_PC(INSTR_PC), .PCPlus4(PCPlus4)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Architectural model: the PC of the next instruction decode should see.
  logic [31:0] expPc;
  logic [31:0] lastPc;
  int consumed;
  int lastConsumeCyc;

  // Memory model: at most one request in flight, fixed content per address.
  bit          memBusy;
  logic [31:0] memAddr;
  int          memDue;
  int          memLatMin = 1, memLatMax = 1, gntPct = 100;
  int          lastRvalidCyc = -100;

  bit          prevValid, prevReady, prevReq, prevGnt, prevRedirect, firstAfterReset;
  logic [31:0] prevInstr, prevPc, prevAddr;

  typedef struct {
    logic gnt; logic rvalid; logic [31:0] rdata; logic ready;
    logic expReq; logic [31:0] expAddr; logic expValid; logic [31:0] expInstr; logic [31:0] expPc;
  } vec_t;
  vec_t vecs[8];

  function automatic logic [31:0] wordAt(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0050_0093;
      32'h4:   return 32'h0010_0113;
      32'h8:   return 32'h0020_81B3;
      default: return (a * 32'h9E37_79B1) ^ 32'hC0DE_0013;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic memTick();
    IMEM_GNT    = 1'b0;
    IMEM_RVALID = 1'b0;
    IMEM_RDATA  = $urandom;
    if (memBusy && cyc >= memDue) begin
      IMEM_RVALID   = 1'b1;
      IMEM_RDATA    = wordAt(memAddr);
      memBusy       = 1'b0;
      lastRvalidCyc = cyc;
    end else if (!memBusy && IMEM_REQ && ($urandom_range(99) < gntPct)) begin
      IMEM_GNT = 1'b1;
      memBusy  = 1'b1;
      memAddr  = IMEM_ADDR;
      memDue   = cyc + $urandom_range(memLatMax, memLatMin);
    end
  endtask

  task automatic checkOutput(input bit ready, input bit pcsrc, input logic [31:0] target);
    logic [31:0] w;
    if (firstAfterReset) begin
      check("req_after_reset", 32'(IMEM_REQ), 32'd1);
      check("addr_after_reset", IMEM_ADDR, RST_PC);
      firstAfterReset = 1'b0;
    end else if (prevReq && !prevGnt && !prevRedirect) begin
      check("req_held", 32'(IMEM_REQ), 32'd1);
      check("addr_held", IMEM_ADDR, prevAddr);
    end
    if (prevRedirect) check("valid_after_redirect", 32'(INSTR_VALID), 32'd0);
    if (prevValid && !prevReady) begin
      check("valid_held", 32'(INSTR_VALID), 32'd1);
      check("instr_held", INSTR, prevInstr);
      check("pc_held", INSTR_PC, prevPc);
    end
    if (INSTR_VALID && ready) begin
      w = wordAt(expPc);
      check("consume_pc", INSTR_PC, expPc);
      check("consume_instr", INSTR, w);
      check("consume_op", 32'(OP6_0), 32'(w[6:0]));
      check("consume_pcplus4", PCPlus4, expPc + 32'd4);
      lastPc = INSTR_PC;
      expPc  = pcsrc ? (target & ~32'd3) : expPc + 32'd4;
      consumed++;
      lastConsumeCyc = cyc;
    end
  endtask

  task automatic applyStimulus(input bit ready, input bit pcsrc, input logic [31:0] target);
    @(negedge CLK);
    cyc++;
    checkOutput(ready, pcsrc, target);
    memTick();
    INSTR_READY  = ready;
    PCSrc        = pcsrc;
    PCTarget     = target;
    prevValid    = INSTR_VALID;
    prevReady    = ready;
    prevReq      = IMEM_REQ;
    prevGnt      = IMEM_GNT;
    prevRedirect = INSTR_VALID & ready & pcsrc;
    prevInstr    = INSTR;
    prevPc       = INSTR_PC;
    prevAddr     = IMEM_ADDR;
  endtask

  task automatic clearModel();
    expPc = RST_PC; memBusy = 1'b0; consumed = 0; lastConsumeCyc = cyc;
    prevValid = 0; prevReady = 0; prevReq = 0; prevGnt = 0; prevRedirect = 0;
  endtask

  task automatic applyReset();
    @(negedge CLK);
    RST = 1'b0; IMEM_GNT = 1'b1; IMEM_RVALID = 1'b0; INSTR_READY = 1'b0; PCSrc = 1'b0;
    #1;
    check("reset_req", 32'(IMEM_REQ), 32'd0);
    check("reset_valid", 32'(INSTR_VALID), 32'd0);
    repeat (3) @(negedge CLK);
    check("reset_req_held", 32'(IMEM_REQ), 32'd0);
    RST = 1'b1; IMEM_GNT = 1'b0;
    clearModel();
    firstAfterReset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    bit seen, staleSeen;
    int startConsumed;
    logic [31:0] firstAddr;

    vecs[0] = '{1'b1, 1'b0, 32'h0,          1'b1, 1'b1, 32'h0, 1'b0, 32'h0,          32'h0};
    vecs[1] = '{1'b0, 1'b1, 32'h0050_0093,  1'b1, 1'b0, 32'h4, 1'b0, 32'h0,          32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h0,          1'b1, 1'b1, 32'h4, 1'b1, 32'h0050_0093,  32'h0};
    vecs[3] = '{1'b0, 1'b1, 32'h0010_0113,  1'b1, 1'b0, 32'h8, 1'b0, 32'h0,          32'h0};
    vecs[4] = '{1'b1, 1'b0, 32'h0,          1'b1, 1'b1, 32'h8, 1'b1, 32'h0010_0113,  32'h4};
    vecs[5] = '{1'b0, 1'b1, 32'h0020_81B3,  1'b1, 1'b0, 32'hC, 1'b0, 32'h0,          32'h0};
    vecs[6] = '{1'b0, 1'b0, 32'h0,          1'b1, 1'b1, 32'hC, 1'b1, 32'h0020_81B3,  32'h8};
    vecs[7] = '{1'b0, 1'b0, 32'h0,          1'b0, 1'b1, 32'hC, 1'b0, 32'h0,          32'h0};

    // Sequential fetch with a 1-cycle memory, cycle by cycle from the table.
    applyReset();
    firstAfterReset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      cyc++;
      check($sformatf("vec%0d_req", i), 32'(IMEM_REQ), 32'(vecs[i].expReq));
      check($sformatf("vec%0d_addr", i), IMEM_ADDR, vecs[i].expAddr);
      check($sformatf("vec%0d_valid", i), 32'(INSTR_VALID), 32'(vecs[i].expValid));
      if (vecs[i].expValid) begin
        check($sformatf("vec%0d_instr", i), INSTR, vecs[i].expInstr);
        check($sformatf("vec%0d_pc", i), INSTR_PC, vecs[i].expPc);
        check($sformatf("vec%0d_op", i), 32'(OP6_0), 32'(vecs[i].expInstr[6:0]));
        check($sformatf("vec%0d_pcplus4", i), PCPlus4, vecs[i].expPc + 32'd4);
      end
      IMEM_GNT = vecs[i].gnt; IMEM_RVALID = vecs[i].rvalid;
      IMEM_RDATA = vecs[i].rdata; INSTR_READY = vecs[i].ready;
    end

    // Backpressure: queue fills, fetch stops, then drains in order.
    $display("[TB] backpressure");
    memLatMin = 1; memLatMax = 1; gntPct = 100;
    applyReset();
    repeat (10) applyStimulus(1'b0, 1'b0, '0);
    check("bp_req_idle", 32'(IMEM_REQ), 32'd0);
    check("bp_valid", 32'(INSTR_VALID), 32'd1);
    check("bp_instr", INSTR, 32'h0050_0093);
    check("bp_pc", INSTR_PC, 32'h0);
    seen = 0; firstAddr = '0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b0, '0);
      if (IMEM_REQ && !seen) begin seen = 1; firstAddr = IMEM_ADDR; end
    end
    check("bp_resume_seen", 32'(seen), 32'd1);
    check("bp_resume_addr", firstAddr, 32'h8);
    check("bp_drained", 32'(consumed >= 2), 32'd1);

    // Redirect while memory is idle and the queue holds 0x8 and 0xC.
    $display("[TB] redirect idle");
    applyReset();
    for (int i = 0; i < 40 && expPc != 32'h8; i++) applyStimulus(1'b1, 1'b0, '0);
    check("ri_reached_8", expPc, 32'h8);
    repeat (8) applyStimulus(1'b0, 1'b0, '0);
    check("ri_queue_full_req", 32'(IMEM_REQ), 32'd0);
    check("ri_head_pc", INSTR_PC, 32'h8);
    applyStimulus(1'b1, 1'b1, 32'h40);
    applyStimulus(1'b0, 1'b0, '0);
    check("ri_target_req", 32'(IMEM_REQ), 32'd1);
    check("ri_target_addr", IMEM_ADDR, 32'h40);
    startConsumed = consumed;
    for (int i = 0; i < 20 && consumed == startConsumed; i++) applyStimulus(1'b1, 1'b0, '0);
    check("ri_next_pc", lastPc, 32'h40);

    // Redirect with a request in flight on a 3-cycle memory.
    $display("[TB] redirect outstanding");
    memLatMin = 3; memLatMax = 3;
    applyReset();
    for (int i = 0; i < 20 && !INSTR_VALID; i++) applyStimulus(1'b0, 1'b0, '0);
    check("ro_first_valid", 32'(INSTR_VALID), 32'd1);
    check("ro_in_flight", 32'(memBusy), 32'd1);
    applyStimulus(1'b1, 1'b1, 32'h102);
    seen = 0; staleSeen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      applyStimulus(1'b1, 1'b0, '0);
      if (INSTR_VALID) staleSeen = 1;
      if (IMEM_REQ) begin
        seen = 1;
        check("ro_req_timing", 32'(cyc), 32'(lastRvalidCyc + 1));
        check("ro_req_addr", IMEM_ADDR, 32'h100);
      end
    end
    check("ro_req_seen", 32'(seen), 32'd1);
    check("ro_no_stale_valid", 32'(staleSeen), 32'd0);
    startConsumed = consumed;
    for (int i = 0; i < 20 && consumed == startConsumed; i++) applyStimulus(1'b1, 1'b0, '0);
    check("ro_next_pc", lastPc, 32'h100);

    // Asynchronous reset while a request is outstanding.
    $display("[TB] async reset in WAIT");
    applyReset();
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0);
    #2 RST = 1'b0;
    #1;
    check("ar_req", 32'(IMEM_REQ), 32'd0);
    check("ar_valid", 32'(INSTR_VALID), 32'd0);
    check("ar_instr", INSTR, 32'h0);
    check("ar_op", 32'(OP6_0), 32'd0);
    check("ar_pc", INSTR_PC, RST_PC);
    check("ar_pcplus4", PCPlus4, RST_PC + 32'd4);
    @(negedge CLK);
    RST = 1'b1; IMEM_GNT = 1'b0; IMEM_RVALID = 1'b0;
    clearModel();
    @(negedge CLK);
    check("ar_req_after", 32'(IMEM_REQ), 32'd1);
    IMEM_GNT = 1'b0; IMEM_RVALID = 1'b1; IMEM_RDATA = 32'hDEAD_BEEF;
    @(negedge CLK);
    IMEM_RVALID = 1'b0;
    check("ar_late_rvalid_ignored", 32'(INSTR_VALID), 32'd0);
    check("ar_still_req", 32'(IMEM_REQ), 32'd1);
    check("ar_still_addr", IMEM_ADDR, RST_PC);
    startConsumed = consumed;
    for (int i = 0; i < 20 && consumed == startConsumed; i++) applyStimulus(1'b1, 1'b0, '0);
    check("ar_first_pc", lastPc, RST_PC);

    // Random traffic against the architectural model.
    $display("[TB] random");
    memLatMin = 1; memLatMax = 4; gntPct = 60;
    applyReset();
    for (int i = 0; i < 2000; i++) begin
      bit rdy, jmp;
      logic [31:0] tgt;
      rdy = ($urandom_range(9) < 7);
      jmp = ($urandom_range(4) == 0);
      case ($urandom_range(2))
        0:       tgt = 32'hFFFF_FFF0 + 32'($urandom_range(15));
        1:       tgt = 32'($urandom_range(255));
        default: tgt = $urandom;
      endcase
      applyStimulus(rdy, jmp, tgt);
      if (cyc - lastConsumeCyc > 200) begin
        check("rand_liveness", 32'(cyc - lastConsumeCyc), 32'd200);
        break;
      end
    end
    check("rand_progress", 32'(consumed >= 50), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
